// File: rtl/dkong3_obj_dma.sv
// Sprite-list DMA: copies I_LEN bytes from CPU work RAM into object RAM, 2 I_CE strobes per byte once granted.
// Dropping I_BUSAK stalls the current read/write in place; it resumes when the grant returns.
module dkong3_obj_dma #(
    parameter int SRC_AW = 16,
    parameter int DST_AW = 10,
    parameter int LEN_W  = 10
) (
    input  logic              I_CLK_24M,
    input  logic              I_RESET,
    input  logic              I_CE,
    input  logic              I_START,
    input  logic [SRC_AW-1:0] I_SRC_BASE,
    input  logic [DST_AW-1:0] I_DST_BASE,
    input  logic [LEN_W-1:0]  I_LEN,
    input  logic              I_BUSAK,
    input  logic [7:0]        I_SRC_D,
    output logic              O_BUSRQ,
    output logic [SRC_AW-1:0] O_SRC_A,
    output logic              O_SRC_RD,
    output logic [DST_AW-1:0] O_OBJ_DMA_A,
    output logic [7:0]        O_OBJ_DMA_D,
    output logic              O_OBJ_DMA_CE,
    output logic              O_OBJ_DMA_WE,
    output logic              O_BUSY,
    output logic              O_DONE
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD, S_WR, S_REL} state_t;

    localparam logic [SRC_AW-1:0] SRC_ONE = SRC_AW'(1);
    localparam logic [DST_AW-1:0] DST_ONE = DST_AW'(1);
    localparam logic [LEN_W-1:0]  CNT_ONE = LEN_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SRC_AW-1:0] r_src_ptr;
    logic [SRC_AW-1:0] r_src_a_hold;
    logic [DST_AW-1:0] r_dst_ptr;
    logic [DST_AW-1:0] r_dst_a_hold;
    logic [LEN_W-1:0]  r_cnt;
    logic [7:0]        r_data;
    logic              w_step;

    assign w_step = I_CE & I_BUSAK;

    always_ff @(posedge I_CLK_24M) begin
        if (I_RESET) begin
            r_state      <= S_IDLE;
            r_src_ptr    <= '0;
            r_src_a_hold <= '0;
            r_dst_ptr    <= '0;
            r_dst_a_hold <= '0;
            r_cnt        <= '0;
            r_data       <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (I_CE && I_START && (I_LEN != '0)) begin
                        r_src_ptr <= I_SRC_BASE;
                        r_dst_ptr <= I_DST_BASE;
                        r_cnt     <= I_LEN;
                    end
                end
                S_RD: begin
                    // Hold registers let the address outputs keep their last driven value.
                    r_src_a_hold <= r_src_ptr;
                    if (w_step) begin
                        r_data <= I_SRC_D;
                    end
                end
                S_WR: begin
                    r_dst_a_hold <= r_dst_ptr;
                    if (w_step) begin
                        r_src_ptr <= r_src_ptr + SRC_ONE;
                        r_dst_ptr <= r_dst_ptr + DST_ONE;
                        r_cnt     <= r_cnt - CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        O_BUSRQ      = 1'b0;
        O_SRC_A      = r_src_a_hold;
        O_SRC_RD     = 1'b0;
        O_OBJ_DMA_A  = r_dst_a_hold;
        O_OBJ_DMA_D  = r_data;
        O_OBJ_DMA_CE = 1'b0;
        O_OBJ_DMA_WE = 1'b0;
        O_DONE       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (I_CE && I_START) begin
                    w_state_nxt = (I_LEN == '0) ? S_REL : S_REQ;
                end
            end
            S_REQ: begin
                O_BUSRQ = 1'b1;
                if (w_step) begin
                    w_state_nxt = S_RD;
                end
            end
            S_RD: begin
                O_BUSRQ  = 1'b1;
                O_SRC_A  = r_src_ptr;
                O_SRC_RD = I_BUSAK;
                if (w_step) begin
                    w_state_nxt = S_WR;
                end
            end
            S_WR: begin
                // CE/WE follow the grant so a revoked bus suppresses the write until regrant.
                O_BUSRQ      = 1'b1;
                O_OBJ_DMA_A  = r_dst_ptr;
                O_OBJ_DMA_CE = I_BUSAK;
                O_OBJ_DMA_WE = I_BUSAK;
                if (w_step) begin
                    w_state_nxt = (r_cnt == CNT_ONE) ? S_REL : S_RD;
                end
            end
            S_REL: begin
                O_DONE      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign O_BUSY = O_BUSRQ;

endmodule
